// File: rtl/fft_seq_ctrl.sv
// Sequencing controller for a radix-2 SDF FFT pipeline: frames input slots, drives
// per-stage counter enables and butterfly phase, and tags pipeline outputs.
module fft_seq_ctrl #(
   parameter int N     = 8,
   parameter int LOG2N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             zero_in,
   output logic [LOG2N-1:0] stage_en,
   output logic [LOG2N-1:0] stage_bfly,
   output logic [LOG2N-2:0] tw_addr,
   output logic             out_valid,
   output logic             out_last,
   output logic [LOG2N-1:0] out_idx,
   output logic             err_underrun
);

   localparam int LMAX = N + LOG2N - 3;
   localparam int LAT  = N - 1 + LOG2N;
   localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);
   localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH} state_t;

   function automatic int stage_ofs(input int s);
      return N - (N >> s) + s;
   endfunction

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [LOG2N-1:0] cnt_q, cnt_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;
   logic             act_d, real_d;
   logic [LMAX:0]    en_sr_q, en_sr_d;
   logic [LAT:0]     tag_sr_q, tag_sr_d;
   logic [LOG2N-1:0] lcnt_q [LOG2N];
   logic [LOG2N-1:0] lcnt_d [LOG2N];
   logic [LOG2N-1:0] ocnt_q, ocnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = 1'b0;
      real_d  = 1'b0;
      zero_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               act_d   = 1'b1;
               real_d  = 1'b1;
               state_d = S_FILL;
               cnt_d   = CNT_ONE;
            end
         end
         S_FILL: begin
            act_d = 1'b1;
            cnt_d = cnt_q + 1'b1;
            // Count wrapped to 0: previous frame is complete, so this slot either
            // opens a back-to-back frame or becomes the first flush slot.
            if (cnt_q == '0 && !in_valid) begin
               state_d = S_FLUSH;
               zero_d  = 1'b1;
            end else begin
               real_d = 1'b1;
               if (!in_valid) begin
                  zero_d = 1'b1;
                  err_d  = 1'b1;
               end
            end
         end
         S_FLUSH: begin
            act_d  = 1'b1;
            zero_d = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      en_sr_d  = {en_sr_q[LMAX-1:0], act_d};
      tag_sr_d = {tag_sr_q[LAT-1:0], real_d};
      for (int s = 0; s < LOG2N; s++)
         lcnt_d[s] = lcnt_q[s] + {{(LOG2N-1){1'b0}}, stage_en[s]};
      ocnt_d = ocnt_q + {{(LOG2N-1){1'b0}}, out_valid};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
         en_sr_q  <= '0;
         tag_sr_q <= '0;
         ocnt_q   <= '0;
         for (int s = 0; s < LOG2N; s++) lcnt_q[s] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         zero_q   <= zero_d;
         err_q    <= err_d;
         en_sr_q  <= en_sr_d;
         tag_sr_q <= tag_sr_d;
         ocnt_q   <= ocnt_d;
         for (int s = 0; s < LOG2N; s++) lcnt_q[s] <= lcnt_d[s];
      end
   end

   // Stage s sees the feed-active flag after the summed latency of stages before it.
   for (genvar s = 0; s < LOG2N; s++) begin : g_stage
      localparam int OFS = stage_ofs(s);
      assign stage_en[s]   = en_sr_q[OFS];
      assign stage_bfly[s] = lcnt_q[s][LOG2N-1-s];
   end

   assign in_ready     = (state_q != S_FLUSH);
   assign zero_in      = zero_q;
   assign err_underrun = err_q;
   assign tw_addr      = stage_bfly[0] ? lcnt_q[0][LOG2N-2:0] : '0;
   assign out_valid    = tag_sr_q[LAT];
   assign out_last     = out_valid && (ocnt_q == CNT_LAST);
   assign out_idx      = bitrev(ocnt_q);

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Scoreboard bench for fft_seq_ctrl: a slot-history model predicts every cycle's
// control outputs and the ordered (index, last) tags of each real output.
module tb_fft_seq_ctrl;

   localparam int N     = 8;
   localparam int LOG2N = 3;
   localparam int LAT   = N - 1 + LOG2N;
   localparam int VW    = 3 * LOG2N + 4;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic             zero_in;
   logic [LOG2N-1:0] stage_en;
   logic [LOG2N-1:0] stage_bfly;
   logic [LOG2N-2:0] tw_addr;
   logic             out_valid;
   logic             out_last;
   logic [LOG2N-1:0] out_idx;
   logic             err_underrun;

   fft_seq_ctrl #(.N(N), .LOG2N(LOG2N)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .zero_in     (zero_in),
      .stage_en    (stage_en),
      .stage_bfly  (stage_bfly),
      .tw_addr     (tw_addr),
      .out_valid   (out_valid),
      .out_last    (out_last),
      .out_idx     (out_idx),
      .err_underrun(err_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          rst_chk;
      logic [VW-1:0] vec;
   } exp_t;

   typedef struct packed {
      logic [LOG2N-1:0] idx;
      logic             last;
   } res_t;

   exp_t exp_q[$];
   res_t res_q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // Reference model state: frame position, remaining flush slots, slot history.
   int pos        = 0;
   int flush_left = 0;
   int nreal      = 0;
   int act_h[$];
   int real_h[$];
   int pre_h[$];

   function automatic int ofs(input int s);
      return N - (N >> s) + s;
   endfunction

   function automatic int brev(input int v);
      int r;
      r = 0;
      for (int i = 0; i < LOG2N; i++)
         if (((v >> i) & 1) != 0) r = r | (1 << (LOG2N - 1 - i));
      return r;
   endfunction

   task automatic model_step(input logic r, input logic v);
      exp_t             e;
      logic             act, rl, z, er, ov, rdy;
      logic [LOG2N-1:0] en, bf;
      logic [LOG2N-2:0] tw;
      int               t, d, lc, lc0;
      if (r) begin
         pos = 0;
         flush_left = 0;
         nreal = 0;
         act_h.delete();
         real_h.delete();
         pre_h.delete();
         pre_h.push_back(0);
         res_q.delete();
         e.rst_chk = 1'b1;
         e.vec = {1'b1, {(VW-1){1'b0}}};
         exp_q.push_back(e);
         return;
      end
      act = 1'b0; rl = 1'b0; z = 1'b0; er = 1'b0;
      if (flush_left > 0) begin
         act = 1'b1; z = 1'b1; flush_left--;
      end else if (pos == 0) begin
         if (v) begin act = 1'b1; rl = 1'b1; pos = 1; end
      end else if (pos == N) begin
         act = 1'b1;
         if (v) begin rl = 1'b1; pos = 1; end
         else begin z = 1'b1; pos = 0; flush_left = N - 1; end
      end else begin
         act = 1'b1; rl = 1'b1; pos++;
         if (!v) begin z = 1'b1; er = 1'b1; end
      end
      act_h.push_back(int'(act));
      real_h.push_back(int'(rl));
      pre_h.push_back(pre_h[pre_h.size()-1] + int'(act));
      t = act_h.size() - 1;
      en = '0; bf = '0; lc0 = 0;
      for (int s = 0; s < LOG2N; s++) begin
         d = t - ofs(s);
         lc = (d >= 0) ? (pre_h[d] % N) : 0;
         en[s] = (d >= 0) ? (act_h[d] != 0) : 1'b0;
         bf[s] = ((lc >> (LOG2N - 1 - s)) & 1) != 0;
         if (s == 0) lc0 = lc;
      end
      tw  = bf[0] ? (LOG2N-1)'(lc0 % (N / 2)) : '0;
      ov  = (t - LAT >= 0) ? (real_h[t-LAT] != 0) : 1'b0;
      rdy = (flush_left == 0);
      e.rst_chk = 1'b0;
      e.vec = {rdy, z, er, ov, 1'b0, en, bf, tw};
      exp_q.push_back(e);
      if (rl) begin
         res_q.push_back({LOG2N'(brev(nreal % N)), (nreal % N) == N - 1});
         nreal++;
      end
   endtask

   task automatic step(input logic r, input logic v);
      @(negedge clk);
      rst = r;
      in_valid = v;
      model_step(r, v);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   // Monitor: one expected control vector per cycle, one tag per out_valid.
   exp_t          m_e;
   res_t          m_r;
   logic [VW-1:0] got;
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         m_e = exp_q.pop_front();
         got = {in_ready, zero_in, err_underrun, out_valid, out_last & ~out_valid,
                stage_en, stage_bfly, tw_addr};
         n_chk++;
         if (got === m_e.vec) n_pass++;
         else $display("FAIL ctrl_vec t=%0t got=%b expected=%b", $time, got, m_e.vec);
         if (m_e.rst_chk) begin
            n_chk++;
            if (out_idx === '0) n_pass++;
            else $display("FAIL reset_idx t=%0t got=%0d expected=0", $time, out_idx);
         end
         if (out_valid === 1'b1) begin
            n_chk++;
            if (res_q.size() == 0) begin
               $display("FAIL out_tag t=%0t unexpected output idx=%0d last=%0b", $time,
                        out_idx, out_last);
            end else begin
               m_r = res_q.pop_front();
               if (out_idx === m_r.idx && out_last === m_r.last) n_pass++;
               else $display("FAIL out_tag t=%0t got idx=%0d last=%0b expected idx=%0d last=%0b",
                             $time, out_idx, out_last, m_r.idx, m_r.last);
            end
         end
      end
   end

   int p;
   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (3) step(1'b1, 1'b0);
      idle(4);
      // single frame
      repeat (N) step(1'b0, 1'b1);
      idle(2 * N + LAT);
      // two frames back-to-back
      repeat (2 * N) step(1'b0, 1'b1);
      idle(2 * N + LAT);
      // one missing sample inside a frame
      for (int i = 0; i < N; i++) step(1'b0, i != 3);
      idle(2 * N + LAT);
      // in_valid held high across the flush
      repeat (N) step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      repeat (2 * N - 1) step(1'b0, 1'b1);
      idle(2 * N + LAT);
      // reset mid-frame, then a fresh frame
      repeat (4) step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      idle(3);
      repeat (N) step(1'b0, 1'b1);
      idle(2 * N + LAT);
      // randomized traffic with occasional resets
      for (int i = 0; i < 900; i++) begin
         case ((i / 100) % 4)
            0: p = 95;
            1: p = 70;
            2: p = 100;
            default: p = 30;
         endcase
         step($urandom_range(0, 249) == 0, $urandom_range(0, 99) < p);
      end
      idle(2 * N + LAT + 2);
      @(posedge clk);
      #2;
      n_chk++;
      if (res_q.size() == 0 && exp_q.size() == 0) n_pass++;
      else $display("FAIL drain pending_tags=%0d pending_cycles=%0d expected=0/0",
                    res_q.size(), exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
